// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the Booth multiplier request/response sequencer.
package mul_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StLaunch = 3'd1;
  localparam state_t StWait   = 3'd2;
  localparam state_t StFormat = 3'd3;
  localparam state_t StResp   = 3'd4;

  localparam logic [1:0] OP_LO  = 2'b00;
  localparam logic [1:0] OP_HI  = 2'b01;
  localparam logic [1:0] OP_SAT = 2'b10;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/mul_seq_if.sv
// Request, multiplier and response signals between the sequencer and its environment.
interface mul_seq_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [1:0]  req_op;

  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic        mul_active;
  logic [66:0] mul_product;
  logic        mul_done;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_ovf;
  logic        rsp_timeout;

  modport slave (
    input  req_valid, req_x, req_y, req_op, mul_product, mul_done, rsp_ready,
    output req_ready, mul_x, mul_y, mul_active, rsp_valid, rsp_data, rsp_ovf, rsp_timeout
  );

  modport master (
    output req_valid, req_x, req_y, req_op, mul_product, mul_done, rsp_ready,
    input  req_ready, mul_x, mul_y, mul_active, rsp_valid, rsp_data, rsp_ovf, rsp_timeout
  );

endinterface

// File: rtl/mul_seq_format.sv
// Reduces a 64-bit signed product to a 32-bit result according to the result-select opcode.
module mul_seq_format
  import mul_seq_pkg::*;
(
  input  logic [63:0] p,
  input  logic [1:0]  op,
  output logic [31:0] data,
  output logic        ovf
);

  logic ovf_lo;

  always_comb begin
    // Low word fits in int32 only if p[63:31] is a pure sign extension.
    ovf_lo = ~((&p[63:31]) | ~(|p[63:31]));
    data   = p[31:0];
    ovf    = ovf_lo;
    case (op)
      OP_HI: begin
        data = p[63:32];
        ovf  = 1'b0;
      end
      OP_SAT: begin
        if (ovf_lo) begin
          data = p[63] ? SAT_NEG : SAT_POS;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_sequencer.sv
// Valid/ready front-end for the iterative Booth multiplier.
// Define MUL_SEQ_TIMEOUT_EN to add a watchdog on the WAIT state.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int unsigned DONE_MASK      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic       clk,
  input logic       rst_b,
  mul_seq_if.slave  bus
);

  localparam int unsigned MaskW = (DONE_MASK > 0) ? $clog2(DONE_MASK + 1) : 1;

  state_t      state_q, state_d;
  logic [MaskW-1:0] mask_q, mask_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic [63:0] prod_q, prod_d;
  logic        active_q, active_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_ovf_q, rsp_ovf_d;

  logic [31:0] fmt_data;
  logic        fmt_ovf;

  // Bits above 63 are only sign extension.
  logic unused_prod_hi;
  assign unused_prod_hi = ^bus.mul_product[66:64];

  mul_seq_format u_format (
    .p    (prod_q),
    .op   (op_q),
    .data (fmt_data),
    .ovf  (fmt_ovf)
  );

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           rsp_timeout_q, rsp_timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    prod_d      = prod_q;
    active_d    = active_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
`ifdef MUL_SEQ_TIMEOUT_EN
    wd_d          = wd_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.req_valid && req_ready_q) begin
          x_d      = bus.req_x;
          y_d      = bus.req_y;
          op_d     = bus.req_op;
          active_d = 1'b1;
          mask_d   = MaskW'(DONE_MASK);
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        // A stale done level from the previous operation is ignored here.
        if (mask_q <= MaskW'(1)) begin
          mask_d  = '0;
          state_d = StWait;
        end else begin
          mask_d = mask_q - MaskW'(1);
        end
      end
      StWait: begin
        if (bus.mul_done) begin
          prod_d   = bus.mul_product[63:0];
          active_d = 1'b0;
          state_d  = StFormat;
`ifdef MUL_SEQ_TIMEOUT_EN
          wd_d     = '0;
        end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
          active_d      = 1'b0;
          rsp_data_d    = '0;
          rsp_ovf_d     = 1'b0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          wd_d          = '0;
          state_d       = StResp;
        end else begin
          wd_d = wd_q + WdW'(1);
`endif
        end
      end
      StFormat: begin
        rsp_data_d  = fmt_data;
        rsp_ovf_d   = fmt_ovf;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d     = StIdle;
        end
      end
      default: begin
        active_d    = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      op_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      prod_q      <= '0;
      active_q    <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
      wd_q          <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      op_q        <= op_d;
      x_q         <= x_d;
      y_q         <= y_d;
      prod_q      <= prod_d;
      active_q    <= active_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
`ifdef MUL_SEQ_TIMEOUT_EN
      wd_q          <= wd_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.mul_x      = x_q;
  assign bus.mul_y      = y_q;
  assign bus.mul_active = active_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
`ifdef MUL_SEQ_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and randomised bench for mul_sequencer with a scoreboard of expected responses.
module tb_mul_sequencer;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_b;
  mul_seq_if bus ();

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  mul_sequencer #(
    .DONE_MASK      (2),
    .TIMEOUT_CYCLES (256)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: product of whatever operands the sequencer presents.
  logic [63:0] model_p;
  always_comb begin
    model_p = {{32{bus.mul_x[31]}}, bus.mul_x} * {{32{bus.mul_y[31]}}, bus.mul_y};
    bus.mul_product = {{3{model_p[63]}}, model_p};
  end

  function automatic exp_t ref_fmt(input logic [31:0] x, input logic [31:0] y,
                                   input logic [1:0] op);
    longint sx, sy, p;
    exp_t   e;
    sx = $signed(x);
    sy = $signed(y);
    p  = sx * sy;
    e.ovf  = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    e.data = p[31:0];
    if (op == 2'b01) begin
      e.data = p[63:32];
      e.ovf  = 1'b0;
    end else if (op == 2'b10 && e.ovf) begin
      e.data = (p < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int bound, output int n);
    n = 0;
    while (!bus.rsp_valid && n < bound) begin
      tick();
      n++;
    end
    chk("rsp_valid_seen", {31'b0, bus.rsp_valid}, 32'd1);
  endtask

  task automatic compare_rsp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_data", bus.rsp_data, e.data);
      chk("rsp_ovf", {31'b0, bus.rsp_ovf}, {31'b0, e.ovf});
      chk("rsp_timeout_clr", {31'b0, bus.rsp_timeout}, 32'd0);
    end
  endtask

  // One full transaction; done is raised so that it is sampled lat edges after acceptance.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op,
                        input int lat, input logic [31:0] exp_data, input logic exp_ovf);
    int   n;
    logic act_ok;
    exp_t e;
    e.data = exp_data;
    e.ovf  = exp_ovf;
    sb.push_back(e);
    bus.req_x     = x;
    bus.req_y     = y;
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("req_ready_low", {31'b0, bus.req_ready}, 32'd0);
    chk("mul_x_latched", bus.mul_x, x);
    act_ok = 1'b1;
    for (int i = 1; i < lat; i++) begin
      if (bus.mul_active !== 1'b1) act_ok = 1'b0;
      tick();
    end
    if (bus.mul_active !== 1'b1) act_ok = 1'b0;
    chk("active_held", {31'b0, act_ok}, 32'd1);
    bus.mul_done = 1'b1;
    tick();
    bus.mul_done = 1'b0;
    chk("active_drop", {31'b0, bus.mul_active}, 32'd0);
    wait_rsp(8, n);
    chk("rsp_latency", 32'(n), 32'd1);
    compare_rsp();
    tick();
    chk("rsp_accepted", {31'b0, bus.rsp_valid}, 32'd0);
    chk("req_ready_back", {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int   n;
    exp_t e;
    logic [31:0] rx, ry;
    logic [1:0]  rop;

    rst_b         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_op    = '0;
    bus.mul_done  = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_active", {31'b0, bus.mul_active}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_mul_x", bus.mul_x, 32'd0);
    chk("rst_timeout", {31'b0, bus.rsp_timeout}, 32'd0);
    rst_b = 1'b1;
    tick();
    chk("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);

    run_op(32'd172, 32'd172, 2'b00, 40, 32'h0000_7390, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 2'b00, 3, 32'hFFFF_FFFF, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 2'b01, 5, 32'h4000_0000, 1'b0);
    run_op(32'h7FFF_FFFF, 32'd2, 2'b10, 4, 32'h7FFF_FFFF, 1'b1);
    run_op(32'h8000_0000, 32'd2, 2'b10, 6, 32'h8000_0000, 1'b1);
    run_op(32'd3, 32'hFFFF_FFFB, 2'b11, 3, 32'hFFFF_FFF1, 1'b0);
    run_op(32'h0001_0000, 32'h0001_0000, 2'b00, 7, 32'h0000_0000, 1'b1);

    for (int k = 0; k < 4; k++) begin
      rx  = $urandom;
      ry  = $urandom;
      rop = 2'($urandom_range(0, 3));
      e   = ref_fmt(rx, ry, rop);
      run_op(rx, ry, rop, int'($urandom_range(3, 12)), e.data, e.ovf);
    end

    // Stale done held across launch, then response back-pressure.
    e.data = 32'd42;
    e.ovf  = 1'b0;
    sb.push_back(e);
    bus.mul_done  = 1'b1;
    bus.req_x     = 32'd7;
    bus.req_y     = 32'd6;
    bus.req_op    = 2'b10;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("stale_e0_active", {31'b0, bus.mul_active}, 32'd1);
    tick();
    chk("stale_e1_active", {31'b0, bus.mul_active}, 32'd1);
    tick();
    chk("stale_e2_active", {31'b0, bus.mul_active}, 32'd1);
    tick();
    chk("stale_e3_drop", {31'b0, bus.mul_active}, 32'd0);
    bus.mul_done  = 1'b0;
    bus.rsp_ready = 1'b0;
    tick();
    chk("stall_valid", {31'b0, bus.rsp_valid}, 32'd1);
    compare_rsp();
    bus.req_x     = 32'd99;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("stall_hold_data", bus.rsp_data, 32'd42);
      chk("stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("stall_mul_x", bus.mul_x, 32'd7);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("stall_release", {31'b0, bus.rsp_valid}, 32'd0);
    chk("stall_ready", {31'b0, bus.req_ready}, 32'd1);

    // Reset while waiting on the multiplier.
    bus.req_x     = 32'd5;
    bus.req_y     = 32'd5;
    bus.req_op    = 2'b00;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("wait_active", {31'b0, bus.mul_active}, 32'd1);
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    chk("wrst_active", {31'b0, bus.mul_active}, 32'd0);
    chk("wrst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("wrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("wrst_rsp_data", bus.rsp_data, 32'd0);
    chk("wrst_mul_x", bus.mul_x, 32'd0);
    chk("wrst_mul_y", bus.mul_y, 32'd0);
    tick();
    chk("wrst_ready_back", {31'b0, bus.req_ready}, 32'd1);

    run_op(32'hFFFF_FFF6, 32'd9, 2'b00, 3, 32'hFFFF_FFA6, 1'b0);

`ifdef MUL_SEQ_TIMEOUT_EN
    bus.mul_done  = 1'b0;
    bus.req_x     = 32'd11;
    bus.req_y     = 32'd13;
    bus.req_op    = 2'b00;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    wait_rsp(300, n);
    chk("to_latency", 32'(n), 32'd258);
    chk("to_flag", {31'b0, bus.rsp_timeout}, 32'd1);
    chk("to_data", bus.rsp_data, 32'd0);
    chk("to_ovf", {31'b0, bus.rsp_ovf}, 32'd0);
    chk("to_active", {31'b0, bus.mul_active}, 32'd0);
    tick();
    chk("to_clear", {31'b0, bus.rsp_timeout}, 32'd0);
    chk("to_ready", {31'b0, bus.req_ready}, 32'd1);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
